// File: rtl/dma_peripheral_responder_pkg.sv
// rtl/dma_peripheral_responder_pkg.sv - state encoding and transfer direction constants
package dma_periph_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_ACK  = 4'b0100,
    ST_XFER = 4'b1000
  } state_e;

  localparam logic DIR_IO_READ  = 1'b0;
  localparam logic DIR_IO_WRITE = 1'b1;

endpackage

// File: rtl/dma_peripheral_responder_if.sv
// rtl/dma_peripheral_responder_if.sv - DMA channel bus between controller and peripheral
interface dma_peripheral_responder_if #(parameter int DATA_WIDTH = 8);
  logic                  DREQ;
  logic                  DACK;
  logic                  IOR_N;
  logic                  IOW_N;
  logic                  EOP_N;
  logic [DATA_WIDTH-1:0] DB_IN;
  logic [DATA_WIDTH-1:0] DB_OUT;
  logic                  DB_OE;

  modport master (input DREQ, DB_OUT, DB_OE, output DACK, IOR_N, IOW_N, EOP_N, DB_IN);
  modport slave  (output DREQ, DB_OUT, DB_OE, input DACK, IOR_N, IOW_N, EOP_N, DB_IN);
endinterface

// File: rtl/dma_peripheral_responder_fifo.sv
// rtl/dma_peripheral_responder_fifo.sv - synchronous FIFO with wrap-bit pointers
module dma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/dma_peripheral_responder.sv
// rtl/dma_peripheral_responder.sv - peripheral end of the DMA single-transfer handshake
module dma_peripheral_responder
  import dma_periph_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dma_peripheral_responder_if.slave bus,
  input  logic                  dir,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  tc,
  input  logic                  tc_clr
);
  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  tc_q, tc_d;
  logic                  ior_q, iow_q;
  logic                  ior_edge, iow_edge, strobe_edge;
  logic                  dma_pop, dma_push, db_oe;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_WIDTH-1:0] tx_head;

  dma_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(CLK), .rst_i(RESET), .push_i(tx_valid), .data_i(tx_data), .pop_i(dma_pop),
    .full_o(tx_full), .empty_o(tx_empty), .head_o(tx_head)
  );

  dma_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(CLK), .rst_i(RESET), .push_i(dma_push), .data_i(bus.DB_IN), .pop_i(rx_ready),
    .full_o(rx_full), .empty_o(rx_empty), .head_o(rx_data)
  );

  // One transfer per falling strobe, however long it is held low.
  assign ior_edge    = ior_q && !bus.IOR_N;
  assign iow_edge    = iow_q && !bus.IOW_N;
  assign strobe_edge = (dir_q == DIR_IO_READ) ? ior_edge : iow_edge;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    dma_pop  = 1'b0;
    dma_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tc_q && ((dir == DIR_IO_READ) ? !tx_empty : !rx_full)) begin
          state_d = ST_REQ;
          dir_d   = dir;
        end
      end
      ST_REQ: begin
        if (bus.DACK) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!bus.DACK) begin
          state_d = ST_IDLE;
        end else if (strobe_edge) begin
          state_d  = ST_XFER;
          dma_pop  = (dir_q == DIR_IO_READ);
          dma_push = (dir_q == DIR_IO_WRITE);
        end
      end
      ST_XFER: begin
        if (!bus.DACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tc_d = tc_q;
    if (!bus.EOP_N && bus.DACK) tc_d = 1'b1;
    else if (tc_clr)            tc_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_IO_READ;
      tc_q    <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      ior_q   <= bus.IOR_N;
      iow_q   <= bus.IOW_N;
    end
  end

  // DREQ follows DACK once granted so it drops in the same cycle DACK does.
  assign bus.DREQ = (state_q == ST_REQ) ||
                    (((state_q == ST_ACK) || (state_q == ST_XFER)) && bus.DACK);
  assign db_oe    = ((state_q == ST_ACK) || (state_q == ST_XFER)) &&
                    (dir_q == DIR_IO_READ) && !bus.IOR_N && bus.DACK;
  assign bus.DB_OE  = db_oe;
  assign bus.DB_OUT = db_oe ? tx_head : '0;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tc       = tc_q;

  a_tx_not_empty_in_ack: assert property (@(posedge CLK) disable iff (RESET)
    (state_q == ST_ACK && dir_q == DIR_IO_READ) |-> !tx_empty);
  a_rx_not_full_in_ack: assert property (@(posedge CLK) disable iff (RESET)
    (state_q == ST_ACK && dir_q == DIR_IO_WRITE) |-> !rx_full);
endmodule

// File: tb/tb_dma_peripheral_responder.sv
// tb/tb_dma_peripheral_responder.sv - directed bench with a queue-based channel model
module tb_dma_peripheral_responder;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       dir, tx_valid, tx_ready, rx_valid, rx_ready, tc, tc_clr;
  logic [7:0] tx_data, rx_data;
  int         checks = 0;
  int         errors = 0;

  dma_peripheral_responder_if #(.DATA_WIDTH(8)) bus();

  dma_peripheral_responder #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .dir(dir),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tc(tc), .tc_clr(tc_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel model: queues for the FIFOs, booleans for request/grant/moved.
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit m_tc, m_req, m_granted, m_moved, m_dir, model_live;
  bit m_prev_ior = 1'b1;
  bit m_prev_iow = 1'b1;

  always @(posedge CLK) begin
    bit ior_fall, iow_fall, move;
    int tx_n, rx_n;
    model_live = 1'b1;
    if (RESET) begin
      tx_m.delete(); rx_m.delete();
      m_tc = 0; m_req = 0; m_granted = 0; m_moved = 0; m_dir = 0;
      m_prev_ior = 1; m_prev_iow = 1;
    end else begin
      tx_n     = tx_m.size();
      rx_n     = rx_m.size();
      ior_fall = m_prev_ior && !bus.IOR_N;
      iow_fall = m_prev_iow && !bus.IOW_N;
      move     = m_req && m_granted && !m_moved && bus.DACK && (m_dir ? iow_fall : ior_fall);
      if (move && !m_dir) void'(tx_m.pop_front());
      if (tx_valid && tx_n < DEPTH) tx_m.push_back(tx_data);
      if (rx_ready && rx_n > 0) void'(rx_m.pop_front());
      if (move && m_dir) rx_m.push_back(bus.DB_IN);
      if (!m_req) begin
        if (!m_tc && (dir ? (rx_n < DEPTH) : (tx_n > 0))) begin
          m_req = 1; m_dir = dir; m_granted = 0; m_moved = 0;
        end
      end else if (!m_granted) m_granted = bus.DACK;
      else if (!bus.DACK)      m_req = 0;
      else if (move)           m_moved = 1;
      if (!bus.EOP_N && bus.DACK) m_tc = 1;
      else if (tc_clr)            m_tc = 0;
      m_prev_ior = bus.IOR_N;
      m_prev_iow = bus.IOW_N;
    end
  end

  always @(negedge CLK) begin
    bit exp_oe;
    if (model_live) begin
      exp_oe = m_req && m_granted && !m_dir && !bus.IOR_N && bus.DACK;
      chk("m_dreq", 32'(bus.DREQ), 32'(m_req && (!m_granted || bus.DACK)));
      chk("m_db_oe", 32'(bus.DB_OE), 32'(exp_oe));
      if (!exp_oe) chk("m_db_out_idle", 32'(bus.DB_OUT), 32'd0);
      else if (!m_moved && tx_m.size() > 0) chk("m_db_out", 32'(bus.DB_OUT), 32'(tx_m[0]));
      chk("m_tx_ready", 32'(tx_ready), 32'(tx_m.size() < DEPTH));
      chk("m_rx_valid", 32'(rx_valid), 32'(rx_m.size() > 0));
      if (rx_m.size() > 0) chk("m_rx_data", 32'(rx_data), 32'(rx_m[0]));
      chk("m_tc", 32'(tc), 32'(m_tc));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (!bus.DREQ && n < 20) begin
      cyc();
      n++;
    end
    chk("dreq_wait", 32'(n < 20), 32'd1);
  endtask

  task automatic dma_xfer(input bit wr, input logic [7:0] d, input bit eop);
    wait_dreq();
    bus.DACK = 1; bus.DB_IN = d; bus.EOP_N = !eop;
    cyc();
    bus.EOP_N = 1;
    if (wr) bus.IOW_N = 0;
    else    bus.IOR_N = 0;
    if (!wr) begin
      @(negedge CLK);
      chk("xfer_db_out", 32'(bus.DB_OUT), 32'(d));
    end
    cyc();
    bus.IOW_N = 1; bus.IOR_N = 1; bus.DACK = 0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    RESET = 1; dir = 0; tx_valid = 0; tx_data = 0; rx_ready = 0; tc_clr = 0;
    bus.DACK = 0; bus.IOR_N = 1; bus.IOW_N = 1; bus.EOP_N = 1; bus.DB_IN = 0;
    cyc(); cyc();
    @(negedge CLK);
    chk("rst_dreq", 32'(bus.DREQ), 32'd0);
    chk("rst_db_oe", 32'(bus.DB_OE), 32'd0);
    chk("rst_db_out", 32'(bus.DB_OUT), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);

    // IOR transfer of 0xA5
    cyc(); RESET = 0; tx_valid = 1; tx_data = 8'hA5;
    cyc(); tx_valid = 0;
    @(negedge CLK); chk("t1_dreq_early", 32'(bus.DREQ), 32'd0);
    cyc();
    @(negedge CLK); chk("t1_dreq", 32'(bus.DREQ), 32'd1);
    cyc(); bus.DACK = 1;
    cyc(); bus.IOR_N = 0;
    @(negedge CLK);
    chk("t1_db_oe", 32'(bus.DB_OE), 32'd1);
    chk("t1_db_out", 32'(bus.DB_OUT), 32'hA5);
    cyc(); bus.IOR_N = 1;
    @(negedge CLK); chk("t1_oe_off", 32'(bus.DB_OE), 32'd0);
    cyc(); bus.DACK = 0;
    @(negedge CLK); chk("t1_dreq_drop", 32'(bus.DREQ), 32'd0);
    cyc(); cyc();
    @(negedge CLK); chk("t1_tx_empty", 32'(bus.DREQ), 32'd0);

    // IOW transfer, strobe held 3 cycles
    cyc(); dir = 1;
    cyc();
    @(negedge CLK); chk("t2_dreq", 32'(bus.DREQ), 32'd1);
    cyc(); bus.DACK = 1; bus.DB_IN = 8'h3C;
    cyc(); bus.IOW_N = 0;
    cyc(); cyc(); cyc(); bus.IOW_N = 1;
    @(negedge CLK);
    chk("t2_rx_valid", 32'(rx_valid), 32'd1);
    chk("t2_rx_data", 32'(rx_data), 32'h3C);
    cyc(); bus.DACK = 0; dir = 0;
    cyc(); cyc(); rx_ready = 1;
    cyc(); rx_ready = 0;
    @(negedge CLK); chk("t2_one_push", 32'(rx_valid), 32'd0);

    // RX full blocks requests
    cyc(); dir = 1;
    dma_xfer(1, 8'h11, 0);
    dma_xfer(1, 8'h22, 0);
    dma_xfer(1, 8'h33, 0);
    dma_xfer(1, 8'h44, 0);
    cyc(); cyc();
    @(negedge CLK);
    chk("t3_full_dreq", 32'(bus.DREQ), 32'd0);
    chk("t3_rx_head", 32'(rx_data), 32'h11);
    cyc(); rx_ready = 1;
    cyc(); rx_ready = 0;
    @(negedge CLK); chk("t3_dreq_wait", 32'(bus.DREQ), 32'd0);
    cyc();
    @(negedge CLK); chk("t3_dreq_after_pop", 32'(bus.DREQ), 32'd1);
    // DACK withdrawn without a strobe
    cyc(); bus.DACK = 1;
    cyc(); bus.DACK = 0; dir = 0;
    @(negedge CLK); chk("t3_abort_dreq", 32'(bus.DREQ), 32'd0);
    cyc(); rx_ready = 1;
    cyc(); cyc(); cyc(); rx_ready = 0;
    @(negedge CLK); chk("t3_rx_drained", 32'(rx_valid), 32'd0);

    // EOP on the second of three words
    cyc(); tx_valid = 1; tx_data = 8'h01;
    cyc(); tx_data = 8'h02;
    cyc(); tx_data = 8'h03;
    cyc(); tx_valid = 0;
    dma_xfer(0, 8'h01, 0);
    dma_xfer(0, 8'h02, 1);
    cyc(); cyc();
    @(negedge CLK);
    chk("t4_tc", 32'(tc), 32'd1);
    chk("t4_dreq_blocked", 32'(bus.DREQ), 32'd0);
    cyc(); tc_clr = 1;
    cyc(); tc_clr = 0;
    cyc();
    @(negedge CLK); chk("t4_dreq_after_clr", 32'(bus.DREQ), 32'd1);

    // RESET in XFER with DB_OE high
    cyc(); tx_valid = 1; tx_data = 8'h77; bus.DACK = 1;
    cyc(); tx_valid = 0; bus.IOR_N = 0;
    @(negedge CLK); chk("t5_db_out", 32'(bus.DB_OUT), 32'h03);
    cyc(); bus.EOP_N = 0;
    @(negedge CLK); chk("t5_oe_xfer", 32'(bus.DB_OE), 32'd1);
    cyc(); bus.EOP_N = 1;
    @(negedge CLK); chk("t5_tc_set", 32'(tc), 32'd1);
    RESET = 1;
    cyc();
    @(negedge CLK);
    chk("t5_rst_oe", 32'(bus.DB_OE), 32'd0);
    chk("t5_rst_dreq", 32'(bus.DREQ), 32'd0);
    chk("t5_rst_tc", 32'(tc), 32'd0);
    cyc(); RESET = 0; bus.DACK = 0; bus.IOR_N = 1;
    cyc(); cyc();
    @(negedge CLK); chk("t5_tx_empty", 32'(bus.DREQ), 32'd0);

    // Wrong-direction strobe is ignored
    cyc(); tx_valid = 1; tx_data = 8'h5A;
    cyc(); tx_valid = 0;
    wait_dreq();
    bus.DACK = 1;
    cyc(); bus.IOW_N = 0;
    cyc(); cyc();
    @(negedge CLK);
    chk("t6_db_oe", 32'(bus.DB_OE), 32'd0);
    chk("t6_dreq", 32'(bus.DREQ), 32'd1);
    cyc(); bus.IOW_N = 1; bus.DACK = 0;
    cyc();
    dma_xfer(0, 8'h5A, 0);
    cyc(); cyc();
    @(negedge CLK); chk("t6_done", 32'(bus.DREQ), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_peripheral_responder.md
Name: dma_peripheral_responder

Overview:
- Peripheral-side endpoint of the DMA single-transfer handshake; the device end that the DMA timing and control logic services.
- Raises DREQ when it has data to deliver (I/O read direction) or space to accept data (I/O write direction).
- Waits for DACK, then sources or sinks one data word per qualified IOR_N/IOW_N strobe.
- Buffers data toward the local device logic in two small FIFOs and honours EOP_N as terminal count.

Parameters:
- DATA_WIDTH, 8, width of DB and both FIFOs.
- FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  out  1  DMA request to the controller.
- DACK  in  1  DMA acknowledge for this channel.
- IOR_N  in  1  I/O read strobe, active low; tri-stated bus is pulled high externally.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N  in  1  end-of-process, active low.
- DB_IN  in  DATA_WIDTH  data bus sampled during IOW_N.
- DB_OUT  out  DATA_WIDTH  data driven during IOR_N.
- DB_OE  out  1  output enable for DB_OUT.
- dir  in  1  0 = device-to-memory (IOR), 1 = memory-to-device (IOW); sampled only in IDLE.
- tx_valid  in  1  local push request into the TX FIFO.
- tx_data  in  DATA_WIDTH  local push data.
- tx_ready  out  1  TX FIFO not full.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  DATA_WIDTH  RX FIFO head.
- rx_ready  in  1  local pop of the RX FIFO.
- tc  out  1  sticky terminal-count flag.
- tc_clr  in  1  clears tc.

Behaviour:
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, tc=0, both FIFOs empty, strobe history registers=1, state=IDLE, latched direction=0.
- Strobes are active only when sampled 1'b0. Strobe edge = previous sample high and current sample low; exactly one transfer per edge, however long the strobe lasts.
- States: IDLE, REQ, ACK, XFER.
- IDLE → REQ when tc==0 and the direction condition holds: TX non-empty if dir=0, RX not full if dir=1. Latch dir on this transition.
- REQ: DREQ=1. → ACK on the cycle DACK is sampled 1. DREQ stays 1 through ACK and XFER until DACK falls.
- ACK: wait for the qualifying strobe edge with DACK=1 (IOR_N if latched dir=0, IOW_N if dir=1), then → XFER. The opposite strobe is ignored.
- XFER, IOR: DB_OUT = TX head combinationally, DB_OE=1 while IOR_N low and DACK high. Pop TX on the edge cycle.
- XFER, IOW: push DB_IN into RX on the edge cycle.
- XFER → IDLE when DACK is sampled 0. DREQ drops in the same cycle DACK falls.
- If the FIFO becomes empty/full mid-ACK (not possible, since local pushes only add to TX and local pops only free RX), no special case is required; assert this in formal.
- EOP_N sampled low while DACK=1 sets tc=1. The current transfer completes; no new REQ is issued until tc_clr. tc_clr and an EOP in the same cycle: set wins.
- Local push with TX full is dropped (tx_ready=0). Local pop with RX empty is ignored.
- Simultaneous local push and DMA pop on TX (or DMA push and local pop on RX) in one cycle are both honoured; count is unchanged.
- DACK falling while in ACK without a strobe: → IDLE, no data moved, DREQ re-evaluated next cycle.
- RESET mid-transfer: immediate return to reset values; FIFO contents discarded.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap bit. full = MSBs differ and remaining bits equal.

Decomposition:
- Package dma_periph_pkg holds the state enum (one-hot, matching the controller's encoding style) and the direction constants DIR_IO_READ=0 and DIR_IO_WRITE=1.
- One sub-module, dma_sync_fifo (parameterised width and depth, push/pop/full/empty/head), instantiated twice for TX and RX.

Test Plan:
- Push 0xA5 with dir=0 → DREQ=1 two cycles later; DACK=1 then a 1-cycle IOR_N low → DB_OUT=0xA5 with DB_OE=1 that cycle; TX empty afterwards; DACK=0 → DREQ=0.
- dir=1, RX empty → DREQ=1; DACK=1, DB_IN=0x3C, IOW_N low for 3 cycles → exactly one push; rx_valid=1, rx_data=0x3C.
- Fill RX to 4 entries → DREQ stays 0; one rx_ready pop → DREQ=1 on the following cycle.
- EOP_N low during the DACK of the 2nd of 3 queued TX words → that word transfers, tc=1, DREQ stays 0 with 1 word left; tc_clr → DREQ=1.
- RESET pulsed in XFER with DB_OE=1 → next cycle DB_OE=0, DREQ=0, TX empty, tc=0.
- IOW_N strobe while dir=0 with DACK=1 → no FIFO change, DB_OE=0.
